bit_serializer: RTL and testbench

BIT_SERIALIZER -- requirements
Module: bit_serializer

---
 rtl/ser_pkg.sv | 14 +
 rtl/bit_serializer.sv | 117 +++++++++++
 tb/tb_bit_serializer.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/ser_pkg.sv
// Shared definitions for the bit serializer: FSM state encoding and the
// default parallel word width.
package ser_pkg;

    // PARITY is only reachable when the parity bit is compiled in.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } ser_state_t;

    localparam int unsigned SER_DATA_W_DEF = 8;

endpackage : ser_pkg

// File: rtl/bit_serializer.sv
// Parallel-to-serial converter feeding a downstream sequence detector.
// Words are taken on an in_valid/in_ready handshake and shifted out MSB
// first, one bit per cycle. Back-to-back words produce no gap cycle.
// Optional feature: define SER_PARITY_EN to append one even-parity bit
// per frame (state PARITY). It is disabled by default, giving DATA_W-bit frames.
module bit_serializer
    import ser_pkg::*;
#(
    parameter int DATA_W = SER_DATA_W_DEF
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              x,
    output logic              x_valid,
    output logic              frame_start
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    ser_state_t        state;
    ser_state_t        state_nxt;
    logic [DATA_W-1:0] shreg;
    logic [CNT_W-1:0]  cnt;
    logic              last_data;
    logic              last_bit;
    logic              xfer;
`ifdef SER_PARITY_EN
    logic              par;
`endif

    // Frame position decode and handshake; in_ready never looks at in_valid.
    always_comb begin
        last_data = (state == SHIFT) && (cnt == CNT_LAST);
`ifdef SER_PARITY_EN
        last_bit  = (state == PARITY);
`else
        last_bit  = last_data;
`endif
        in_ready  = (state == IDLE) || last_bit;
        xfer      = in_valid && in_ready;
    end

    // State register; reset wins over any same-cycle transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                state_nxt = xfer ? SHIFT : IDLE;
            end
            SHIFT: begin
                if (last_data) begin
`ifdef SER_PARITY_EN
                    state_nxt = PARITY;
`else
                    state_nxt = xfer ? SHIFT : IDLE;
`endif
                end
            end
`ifdef SER_PARITY_EN
            PARITY: begin
                state_nxt = xfer ? SHIFT : IDLE;
            end
`endif
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Shift register, bit counter and parity: load on transfer, shift in SHIFT.
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg <= '0;
            cnt   <= '0;
`ifdef SER_PARITY_EN
            par   <= 1'b0;
`endif
        end else if (xfer) begin
            shreg <= in_data;
            cnt   <= '0;
`ifdef SER_PARITY_EN
            par   <= ^in_data;
`endif
        end else if (state == SHIFT) begin
            shreg <= {shreg[DATA_W-2:0], 1'b0};
            cnt   <= cnt + CNT_W'(1);
        end
    end

    // Outputs decoded from registers only; x is forced low outside a frame.
    always_comb begin
        x_valid     = (state != IDLE);
        frame_start = (state == SHIFT) && (cnt == '0);
        case (state)
            SHIFT:   x = shreg[DATA_W-1];
`ifdef SER_PARITY_EN
            PARITY:  x = par;
`endif
            default: x = 1'b0;
        endcase
    end

endmodule : bit_serializer

// File: tb/tb_bit_serializer.sv
// Directed bench for bit_serializer: an 8-bit instance carries most of the
// sequences, a 4-bit instance checks the narrow frame. A small overlapping
// "1001" Mealy detector models the downstream consumer of x.
module tb_bit_serializer;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready, x, x_valid, frame_start;

    logic [3:0] in_data4;
    logic       in_valid4;
    logic       in_ready4, x4, x_valid4, frame_start4;

    int unsigned errors = 0;
    int unsigned checks = 0;

    logic [1:0] dstate;
    logic       z;

    always #5 clk = ~clk;

    bit_serializer #(.DATA_W(8)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .x(x), .x_valid(x_valid), .frame_start(frame_start)
    );

    bit_serializer #(.DATA_W(4)) dut4 (
        .clk(clk), .rst(rst), .in_data(in_data4), .in_valid(in_valid4),
        .in_ready(in_ready4), .x(x4), .x_valid(x_valid4), .frame_start(frame_start4)
    );

    // Downstream "1001" detector, overlapping, Mealy output; consumes x mid-cycle.
    assign z = (dstate == 2'd3) && x;
    always @(negedge clk) begin
        if (rst) dstate <= 2'd0;
        else begin
            case (dstate)
                2'd0: dstate <= x ? 2'd1 : 2'd0;
                2'd1: dstate <= x ? 2'd1 : 2'd2;
                2'd2: dstate <= x ? 2'd1 : 2'd3;
                default: dstate <= x ? 2'd1 : 2'd0;
            endcase
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".x"}, x, 1'b0);
        chk({tag, ".x_valid"}, x_valid, 1'b0);
        chk({tag, ".frame_start"}, frame_start, 1'b0);
        chk({tag, ".in_ready"}, in_ready, 1'b1);
    endtask

    // Walk n serial bits of the 8-bit instance; bits is MSB-first, fs/rdy/zm indexed by bit number.
    task automatic frame8(input string tag, input logic [15:0] bits, input int n,
                          input logic [15:0] fs, input logic [15:0] rdy,
                          input int drop_at, input bit chk_z, input logic [15:0] zm);
        for (int i = 0; i < n; i++) begin
            string t;
            t = $sformatf("%s.b%0d", tag, i + 1);
            chk({t, ".x"}, x, bits[n-1-i]);
            chk({t, ".x_valid"}, x_valid, 1'b1);
            chk({t, ".frame_start"}, frame_start, fs[i]);
            chk({t, ".in_ready"}, in_ready, rdy[i]);
            if (chk_z) chk({t, ".z"}, z, zm[i]);
            tick();
            if (i == drop_at) in_valid = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0;
        in_valid4 = 1'b0; in_data4 = '0;
        tick();
        tick();
        chk_idle("reset");
        chk("reset.in_ready4", in_ready4, 1'b1);
        chk("reset.x_valid4", x_valid4, 1'b0);
        rst = 1'b0;

        // Idle after reset: nothing presented for 10 cycles.
        for (int i = 0; i < 10; i++) begin
            tick();
            chk_idle($sformatf("idle.c%0d", i));
        end

`ifdef SER_PARITY_EN
        // 8'h07: three ones -> parity 1; 8'h03: two ones -> parity 0.
        in_data = 8'h07; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        frame8("p07", 16'h000F, 9, 16'h0001, 16'h0100, -1, 1'b0, 16'h0000);
        chk_idle("p07.after");
        in_data = 8'h03; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        frame8("p03", 16'h0006, 9, 16'h0001, 16'h0100, -1, 1'b0, 16'h0000);
        chk_idle("p03.after");
`else
        // 8'h90: 1,0,0,1,0,0,0,0; detector fires on bit 4.
        in_data = 8'h90; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        frame8("f90", 16'h0090, 8, 16'h0001, 16'h0080, -1, 1'b1, 16'h0008);
        chk_idle("f90.after");

        // Back-to-back 8'hA5 then 8'h3C with in_valid held: no gap cycle.
        in_data = 8'hA5; in_valid = 1'b1;
        tick();
        in_data = 8'h3C;
        frame8("b2b", 16'hA53C, 16, 16'h0101, 16'h8080, 7, 1'b0, 16'h0000);
        chk_idle("b2b.after");

        // Reset during bit 3 of 8'hFF, with a transfer offered at the same time.
        in_data = 8'hFF; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("rstmid.b1.x", x, 1'b1);
        tick();
        chk("rstmid.b2.x", x, 1'b1);
        tick();
        chk("rstmid.b3.x", x, 1'b1);
        chk("rstmid.b3.x_valid", x_valid, 1'b1);
        rst = 1'b1; in_data = 8'h81; in_valid = 1'b1;
        tick();
        chk_idle("rstmid.after");
        // in_ready is high now, but rst still has priority over the transfer.
        tick();
        chk_idle("rstprio");
        rst = 1'b0;
        tick();
        in_valid = 1'b0;
        frame8("f81", 16'h0081, 8, 16'h0001, 16'h0080, -1, 1'b0, 16'h0000);
        chk_idle("f81.after");

        // DATA_W=4: 4'b1001, then back to IDLE with in_valid low.
        in_data4 = 4'b1001; in_valid4 = 1'b1;
        tick();
        in_valid4 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            logic [3:0] w;
            w = 4'b1001;
            chk($sformatf("w4.b%0d.x", i + 1), x4, w[3-i]);
            chk($sformatf("w4.b%0d.x_valid", i + 1), x_valid4, 1'b1);
            chk($sformatf("w4.b%0d.frame_start", i + 1), frame_start4, i == 0);
            chk($sformatf("w4.b%0d.in_ready", i + 1), in_ready4, i == 3);
            tick();
        end
        chk("w4.after.x_valid", x_valid4, 1'b0);
        chk("w4.after.x", x4, 1'b0);
        chk("w4.after.in_ready", in_ready4, 1'b1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Bound the whole run so a stuck sequence still reports.
    initial begin
        #200000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule : tb_bit_serializer
